// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the PC register, the fetch stage and the ROM bus interface users.
package fetch_pkg;

    localparam int ADDRESS_WIDTH = 16;
    localparam int DATA_WIDTH    = 32;

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_REDIR
    } next_pc_sel_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    instr;
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [ADDRESS_WIDTH-1:0] pc_plus;
        logic                     valid;
    } if_id_t;

    localparam if_id_t IF_ID_RESET = '{
        instr:   NOP_INSTR,
        pc:      '0,
        pc_plus: '0,
        valid:   1'b0
    };

    // Redirect targets are word aligned; the low two bits are dropped.
    function automatic logic [ADDRESS_WIDTH-1:0] align_pc(
        input logic [ADDRESS_WIDTH-1:0] addr
    );
        return {addr[ADDRESS_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction ROM bus: fetch side drives the address, ROM returns
// the instruction combinationally in the same cycle.
interface fetch_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);

    logic [ADDRESS_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0]    instr_i;

    modport master (
        output pc_o,
        input  instr_i
    );

    modport slave (
        input  pc_o,
        output instr_i
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter register with next-PC mux and wrapping increment.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = fetch_pkg::ADDRESS_WIDTH,
    parameter int PC_INCR       = 4,
    parameter int RESET_PC      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  next_pc_sel_e             sel,
    input  logic [ADDRESS_WIDTH-1:0] target,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pc_inc
);

    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_next;

    // Truncation to ADDRESS_WIDTH gives the silent wrap at the top address.
    assign pc_inc = pc_q + ADDRESS_WIDTH'(PC_INCR);
    assign pc     = pc_q;

    always_comb begin
        pc_next = pc_q;
        unique case (sel)
            SEL_SEQ:   pc_next = pc_inc;
            SEL_HOLD:  pc_next = pc_q;
            SEL_REDIR: pc_next = align_pc(target);
            default:   pc_next = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= ADDRESS_WIDTH'(RESET_PC);
        end else begin
            pc_q <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, ROM addressing and the IF/ID register,
// with hazard-unit stall/flush and a count of instructions passed to decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = fetch_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = fetch_pkg::DATA_WIDTH,
    parameter int PC_INCR       = 4,
    parameter int RESET_PC      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_f,
    input  logic                     stall_d,
    input  logic                     flush_d,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    fetch_if.master                  rom,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus_d,
    output logic                     valid_d,
    output logic [31:0]              fetch_count
);

    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_inc;
    next_pc_sel_e             sel;
    if_id_t                   if_id;

    // A taken redirect wins over a PC stall.
    always_comb begin
        sel = SEL_SEQ;
        if (redirect_valid) begin
            sel = SEL_REDIR;
        end else if (stall_f) begin
            sel = SEL_HOLD;
        end
    end

    pc_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .PC_INCR       (PC_INCR),
        .RESET_PC      (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .sel    (sel),
        .target (redirect_target),
        .pc     (pc),
        .pc_inc (pc_inc)
    );

    assign rom.pc_o = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id       <= IF_ID_RESET;
            fetch_count <= '0;
        end else if (flush_d || redirect_valid) begin
            if_id.instr <= NOP_INSTR;
            if_id.valid <= 1'b0;
        end else if (!stall_d) begin
            // A held PC would re-present the same word, so insert a bubble.
            if (stall_f) begin
                if_id.instr <= NOP_INSTR;
                if_id.valid <= 1'b0;
            end else begin
                if_id.instr   <= rom.instr_i;
                if_id.pc      <= pc;
                if_id.pc_plus <= pc_inc;
                if_id.valid   <= 1'b1;
                fetch_count   <= fetch_count + 32'd1;
            end
        end
    end

    assign instr_d   = if_id.instr;
    assign pc_d      = if_id.pc;
    assign pc_plus_d = if_id.pc_plus;
    assign valid_d   = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reference model pushes expected
// IF/ID and PC state into a scoreboard queue, popped after each edge.
module tb_fetch_stage;

    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [31:0] instr_d;
    logic [15:0] pc_d;
    logic [15:0] pc_plus_d;
    logic        valid_d;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    fetch_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus ();

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    assign bus.instr_i = rom_word(bus.pc_o);

    fetch_stage #(
        .ADDRESS_WIDTH (16),
        .DATA_WIDTH    (32),
        .PC_INCR       (4),
        .RESET_PC      (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_f         (stall_f),
        .stall_d         (stall_d),
        .flush_d         (flush_d),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .rom             (bus.master),
        .instr_d         (instr_d),
        .pc_d            (pc_d),
        .pc_plus_d       (pc_plus_d),
        .valid_d         (valid_d),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] instr;
        logic [15:0] pcd;
        logic [15:0] pcp;
        logic        v;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [15:0] m_pc    = '0;
    logic [31:0] m_instr = '0;
    logic [15:0] m_pcd   = '0;
    logic [15:0] m_pcp   = '0;
    logic        m_v     = 1'b0;
    logic [31:0] m_cnt   = '0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic sf, input logic sd,
                        input logic fd, input logic rv,
                        input logic [15:0] rt);
        exp_t e;
        rst             = r;
        stall_f         = sf;
        stall_d         = sd;
        flush_d         = fd;
        redirect_valid  = rv;
        redirect_target = rt;
        if (r) begin
            m_pc = 16'h0000; m_instr = 32'h0000_0013;
            m_pcd = '0; m_pcp = '0; m_v = 1'b0; m_cnt = '0;
        end else begin
            if (fd || rv) begin
                m_instr = 32'h0000_0013; m_v = 1'b0;
            end else if (sd) begin
                m_instr = m_instr;
            end else if (sf) begin
                m_instr = 32'h0000_0013; m_v = 1'b0;
            end else begin
                m_instr = rom_word(m_pc);
                m_pcd   = m_pc;
                m_pcp   = m_pc + 16'd4;
                m_v     = 1'b1;
                m_cnt   = m_cnt + 1;
            end
            if (rv) m_pc = {rt[15:2], 2'b00};
            else if (!sf) m_pc = m_pc + 16'd4;
        end
        e = '{pc: m_pc, instr: m_instr, pcd: m_pcd, pcp: m_pcp,
              v: m_v, cnt: m_cnt};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc_o", 32'(bus.pc_o), 32'(e.pc));
        check("instr_d", instr_d, e.instr);
        check("pc_d", 32'(pc_d), 32'(e.pcd));
        check("pc_plus_d", 32'(pc_plus_d), 32'(e.pcp));
        check("valid_d", 32'(valid_d), 32'(e.v));
        check("fetch_count", fetch_count, e.cnt);
    endtask

    initial begin
        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0;
        flush_d = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        #1;
        step(1, 0, 0, 0, 0, 16'h0);
        check("rst_pc", 32'(bus.pc_o), 32'h0);
        check("rst_instr", instr_d, 32'h0000_0013);
        check("rst_valid", 32'(valid_d), 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 16'h0);
        check("run_pc", 32'(bus.pc_o), 32'h10);
        check("run_cnt", fetch_count, 32'd4);
        check("run_pcd", 32'(pc_d), 32'hC);
        step(0, 1, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 0, 16'h0);
        check("stall_pc", 32'(bus.pc_o), 32'h10);
        check("stall_valid", 32'(valid_d), 32'h0);
        check("stall_cnt", fetch_count, 32'd4);
        step(0, 0, 0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0043);
        check("redir_pc", 32'(bus.pc_o), 32'h40);
        check("redir_bubble", 32'(valid_d), 32'h0);
        step(0, 0, 0, 0, 0, 16'h0);
        check("redir_instr", instr_d, rom_word(16'h0040));
        check("redir_link", 32'(pc_plus_d), 32'h44);
        step(0, 0, 1, 1, 0, 16'h0);
        check("flush_wins", 32'(valid_d), 32'h0);
        step(0, 0, 0, 0, 0, 16'h0);
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 1, 1, 0, 0, 16'h0);
        step(0, 0, 1, 0, 1, 16'h0100);
        step(0, 0, 0, 0, 1, 16'hFFFE);
        check("top_pc", 32'(bus.pc_o), 32'hFFFC);
        step(0, 0, 0, 0, 0, 16'h0);
        check("wrap_pc", 32'(bus.pc_o), 32'h0);
        check("wrap_link", 32'(pc_plus_d), 32'h0);
        check("wrap_pcd", 32'(pc_d), 32'hFFFC);
        step(0, 0, 0, 0, 0, 16'h0);
        step(1, 0, 1, 0, 0, 16'h0);
        check("mid_rst_pc", 32'(bus.pc_o), 32'h0);
        check("mid_rst_valid", 32'(valid_d), 32'h0);
        check("mid_rst_instr", instr_d, 32'h0000_0013);
        check("mid_rst_cnt", fetch_count, 32'h0);
        step(0, 0, 0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 0, 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
